// File: rtl/lap_register_ctrl.sv
// Lap-time store: circular register file of stopwatch epochs, replayed
// oldest-first to the LCD writer over a req/ack handshake.
module lap_register_ctrl #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int TIME_W = 28
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              save,
    input  logic              retrieve,
    input  logic              clear,
    input  logic [TIME_W-1:0] time_in,
    input  logic              lcd_ack,
    output logic              reg_busy,
    output logic              lcd_req,
    output logic [TIME_W-1:0] lcd_data,
    output logic [ADDR_W-1:0] lcd_index,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT_ACK,
        CLEAR
    } state_t;

    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

    state_t            state;
    logic [TIME_W-1:0] mem [DEPTH];
    logic [TIME_W-1:0] save_word;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] cursor;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] oldest;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   cursor_nxt;

    // count == DEPTH has zero low bits, so oldest == wr_ptr when full
    assign oldest     = wr_ptr - count[ADDR_W-1:0];
    assign rd_addr    = oldest + cursor;
    assign cursor_nxt = {1'b0, cursor} + 1'b1;
    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            reg_busy  <= 1'b0;
            lcd_req   <= 1'b0;
            lcd_data  <= '0;
            lcd_index <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            cursor    <= '0;
            clr_addr  <= '0;
            save_word <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear) begin
                        count    <= '0;
                        wr_ptr   <= '0;
                        cursor   <= '0;
                        clr_addr <= '0;
                        state    <= CLEAR;
                        reg_busy <= 1'b1;
                    end else if (save) begin
                        save_word <= time_in;
                        state     <= WRITE;
                        reg_busy  <= 1'b1;
                    end else if (retrieve && !empty) begin
                        state    <= READ;
                        reg_busy <= 1'b1;
                    end
                end
                WRITE: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (!full) begin
                        count <= count + 1'b1;
                    end
                    cursor   <= '0;
                    state    <= IDLE;
                    reg_busy <= 1'b0;
                end
                READ: begin
                    lcd_data  <= mem[rd_addr];
                    lcd_index <= cursor;
                    lcd_req   <= 1'b1;
                    state     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (lcd_ack) begin
                        lcd_req  <= 1'b0;
                        cursor   <= (cursor_nxt == count) ? '0
                                    : cursor_nxt[ADDR_W-1:0];
                        state    <= IDLE;
                        reg_busy <= 1'b0;
                    end
                end
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_ADDR) begin
                        state    <= IDLE;
                        reg_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    reg_busy <= 1'b0;
                    lcd_req  <= 1'b0;
                end
            endcase
        end
    end

    // Storage is not reset; writes are gated so none lands while in reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == WRITE) begin
                mem[wr_ptr] <= save_word;
            end else if (state == CLEAR) begin
                mem[clr_addr] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lap_register_ctrl.sv
// Directed bench for lap_register_ctrl: save, replay, wrap, clear,
// dropped strobes and asynchronous reset during a handshake.
module tb_lap_register_ctrl;

    localparam int TW = 28;
    localparam int AW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          save = 1'b0;
    logic          retrieve = 1'b0;
    logic          clear = 1'b0;
    logic [TW-1:0] time_in = '0;
    logic          lcd_ack = 1'b0;
    logic          reg_busy;
    logic          lcd_req;
    logic [TW-1:0] lcd_data;
    logic [AW-1:0] lcd_index;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int errors = 0;
    int checks = 0;

    lap_register_ctrl #(.DEPTH(8), .ADDR_W(AW), .TIME_W(TW)) dut (
        .clock     (clock),
        .reset     (reset),
        .save      (save),
        .retrieve  (retrieve),
        .clear     (clear),
        .time_in   (time_in),
        .lcd_ack   (lcd_ack),
        .reg_busy  (reg_busy),
        .lcd_req   (lcd_req),
        .lcd_data  (lcd_data),
        .lcd_index (lcd_index),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #10 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic save_lap(input logic [TW-1:0] v);
        time_in = v;
        save = 1'b1;
        tick();
        save = 1'b0;
        tick();
    endtask

    task automatic retrieve_lap(input int ack_delay,
                                output logic [TW-1:0] d,
                                output logic [AW-1:0] idx,
                                output logic ok);
        int n;
        ok = 1'b1;
        retrieve = 1'b1;
        tick();
        retrieve = 1'b0;
        n = 0;
        while (!lcd_req && n < 6) begin
            tick();
            n++;
        end
        if (!lcd_req) ok = 1'b0;
        d = lcd_data;
        idx = lcd_index;
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            if (!lcd_req || lcd_data !== d) ok = 1'b0;
        end
        lcd_ack = 1'b1;
        tick();
        if (lcd_req || reg_busy) ok = 1'b0;
        lcd_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic seen;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (reg_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", reg_busy);
        end
        checks++;
        if (lcd_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b want 0", lcd_req);
        end
        checks++;
        if (lcd_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", lcd_data);
        end
        checks++;
        if (lcd_index !== '0) begin
            errors++;
            $display("FAIL reset_index: got %0d want 0", lcd_index);
        end
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", count);
        end
        checks++;
        if (full !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: got full=%b empty=%b want 0/1",
                     full, empty);
        end
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (lcd_req || reg_busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: got activity=%b want 0", seen);
        end
    endtask

    task automatic test_save_retrieve();
        logic held;
        reset_dut();
        time_in = 28'h0123456;
        save = 1'b1;
        tick();
        save = 1'b0;
        checks++;
        if (reg_busy !== 1'b1) begin
            errors++;
            $display("FAIL save_busy: got %b want 1", reg_busy);
        end
        tick();
        checks++;
        if (reg_busy !== 1'b0 || count !== 4'd1) begin
            errors++;
            $display("FAIL save_done: got busy=%b count=%0d want 0/1",
                     reg_busy, count);
        end
        retrieve = 1'b1;
        tick();
        retrieve = 1'b0;
        checks++;
        if (lcd_req !== 1'b0 || reg_busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_cycle1: got req=%b busy=%b want 0/1",
                     lcd_req, reg_busy);
        end
        tick();
        checks++;
        if (lcd_req !== 1'b1) begin
            errors++;
            $display("FAIL rd_req_rise: got %b want 1", lcd_req);
        end
        checks++;
        if (lcd_data !== 28'h0123456 || lcd_index !== 3'd0) begin
            errors++;
            $display("FAIL rd_data: got %h/%0d want 0123456/0",
                     lcd_data, lcd_index);
        end
        held = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (lcd_req !== 1'b1 || lcd_data !== 28'h0123456) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL rd_hold: got %b want 1", held);
        end
        lcd_ack = 1'b1;
        tick();
        lcd_ack = 1'b0;
        checks++;
        if (lcd_req !== 1'b0 || reg_busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_ack_drop: got req=%b busy=%b want 0/0",
                     lcd_req, reg_busy);
        end
        checks++;
        if (lcd_data !== 28'h0123456) begin
            errors++;
            $display("FAIL rd_data_keep: got %h want 0123456", lcd_data);
        end
    endtask

    task automatic test_wrap();
        logic [TW-1:0] d;
        logic [AW-1:0] idx;
        logic ok;
        reset_dut();
        for (int v = 1; v <= 10; v++) save_lap(TW'(v));
        checks++;
        if (count !== 4'd8 || full !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL wrap_full: got count=%0d full=%b empty=%b want 8/1/0",
                     count, full, empty);
        end
        for (int i = 0; i < 9; i++) begin
            retrieve_lap(i % 3, d, idx, ok);
            checks++;
            if (ok !== 1'b1) begin
                errors++;
                $display("FAIL wrap_hs%0d: got %b want 1", i, ok);
            end
            checks++;
            if (d !== TW'((i % 8) + 3) || idx !== AW'(i % 8)) begin
                errors++;
                $display("FAIL wrap_rd%0d: got %0d/%0d want %0d/%0d",
                         i, d, idx, (i % 8) + 3, i % 8);
            end
        end
    endtask

    task automatic test_early_ack();
        lcd_ack = 1'b1;
        retrieve = 1'b1;
        tick();
        retrieve = 1'b0;
        checks++;
        if (reg_busy !== 1'b1 || lcd_req !== 1'b0) begin
            errors++;
            $display("FAIL early_read: got busy=%b req=%b want 1/0",
                     reg_busy, lcd_req);
        end
        tick();
        checks++;
        if (lcd_req !== 1'b1 || lcd_data !== 28'd4 || lcd_index !== 3'd1) begin
            errors++;
            $display("FAIL early_wait: got req=%b data=%0d idx=%0d want 1/4/1",
                     lcd_req, lcd_data, lcd_index);
        end
        tick();
        lcd_ack = 1'b0;
        checks++;
        if (lcd_req !== 1'b0 || reg_busy !== 1'b0) begin
            errors++;
            $display("FAIL early_done: got req=%b busy=%b want 0/0",
                     lcd_req, reg_busy);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        time_in = 28'hABCDEF0;
        save = 1'b1;
        retrieve = 1'b1;
        tick();
        save = 1'b0;
        retrieve = 1'b0;
        tick();
        tick();
        checks++;
        if (count !== 4'd1 || reg_busy !== 1'b0 || lcd_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_prio: got count=%0d busy=%b req=%b want 1/0/0",
                     count, reg_busy, lcd_req);
        end
        retrieve = 1'b1;
        tick();
        retrieve = 1'b0;
        tick();
        time_in = 28'h1111111;
        retrieve = 1'b1;
        save = 1'b1;
        tick();
        retrieve = 1'b0;
        save = 1'b0;
        checks++;
        if (lcd_req !== 1'b1 || lcd_data !== 28'hABCDEF0
            || lcd_index !== 3'd0) begin
            errors++;
            $display("FAIL b2b_inflight: got req=%b data=%h idx=%0d want 1/abcdef0/0",
                     lcd_req, lcd_data, lcd_index);
        end
        lcd_ack = 1'b1;
        tick();
        lcd_ack = 1'b0;
        tick();
        tick();
        checks++;
        if (reg_busy !== 1'b0 || lcd_req !== 1'b0 || count !== 4'd1) begin
            errors++;
            $display("FAIL b2b_dropped: got busy=%b req=%b count=%0d want 0/0/1",
                     reg_busy, lcd_req, count);
        end
    endtask

    task automatic test_clear();
        int busy_cycles;
        logic [TW-1:0] d;
        logic [AW-1:0] idx;
        logic ok;
        reset_dut();
        for (int v = 0; v < 5; v++) save_lap(TW'(8'h11 + v));
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL clr_pre: got %0d want 5", count);
        end
        clear = 1'b1;
        save = 1'b1;
        tick();
        clear = 1'b0;
        save = 1'b0;
        checks++;
        if (count !== '0 || empty !== 1'b1 || reg_busy !== 1'b1) begin
            errors++;
            $display("FAIL clr_now: got count=%0d empty=%b busy=%b want 0/1/1",
                     count, empty, reg_busy);
        end
        busy_cycles = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!reg_busy) break;
            busy_cycles++;
        end
        checks++;
        if (busy_cycles != 8 || count !== '0) begin
            errors++;
            $display("FAIL clr_len: got busy=%0d count=%0d want 8/0",
                     busy_cycles, count);
        end
        retrieve = 1'b1;
        tick();
        retrieve = 1'b0;
        checks++;
        if (reg_busy !== 1'b0 || lcd_req !== 1'b0) begin
            errors++;
            $display("FAIL clr_empty_rd: got busy=%b req=%b want 0/0",
                     reg_busy, lcd_req);
        end
        save_lap(28'h0000777);
        for (int i = 0; i < 2; i++) begin
            retrieve_lap(1, d, idx, ok);
            checks++;
            if (ok !== 1'b1 || d !== 28'h0000777 || idx !== 3'd0) begin
                errors++;
                $display("FAIL clr_new%0d: got ok=%b data=%h idx=%0d want 1/0000777/0",
                         i, ok, d, idx);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        save_lap(28'h5A5A5A5);
        retrieve = 1'b1;
        tick();
        retrieve = 1'b0;
        tick();
        checks++;
        if (lcd_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got req=%b want 1", lcd_req);
        end
        #5;
        reset = 1'b1;
        #1;
        checks++;
        if (lcd_req !== 1'b0 || reg_busy !== 1'b0 || count !== '0
            || lcd_data !== '0) begin
            errors++;
            $display("FAIL rst_async: got req=%b busy=%b count=%0d data=%h want 0/0/0/0",
                     lcd_req, reg_busy, count, lcd_data);
        end
        #3;
        reset = 1'b0;
        lcd_ack = 1'b1;
        tick();
        tick();
        lcd_ack = 1'b0;
        checks++;
        if (lcd_req !== 1'b0 || reg_busy !== 1'b0 || count !== '0
            || empty !== 1'b1) begin
            errors++;
            $display("FAIL rst_stray_ack: got req=%b busy=%b count=%0d empty=%b want 0/0/0/1",
                     lcd_req, reg_busy, count, empty);
        end
    endtask

    initial begin
        test_reset();
        test_save_retrieve();
        test_wrap();
        test_early_ack();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
